// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer engine.
// Holds the per-channel sprite register layout plus screen and transparency constants.
`timescale 1ns/1ps
package sprite_pkg;

  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int TRANSPARENT_IDX = 0;
  localparam int COORD_W         = 10;
  // Storage width of the animation field; the engine's ANIM_W must not exceed it.
  localparam int SPRITE_ANIM_W   = 2;

  typedef struct packed {
    logic [COORD_W-1:0]       x;
    logic [COORD_W-1:0]       y;
    logic [SPRITE_ANIM_W-1:0] anim;
    logic                     vis;
  } sprite_t;

  // Pixel-minus-origin as an 11-bit signed value, so origins right of or
  // below the pixel give a negative offset instead of wrapping.
  function automatic logic signed [COORD_W:0] coord_diff(
    input logic [COORD_W-1:0] pix,
    input logic [COORD_W-1:0] org
  );
    return $signed({1'b0, pix}) - $signed({1'b0, org});
  endfunction

  // True when a signed offset lies inside [0, size).
  function automatic logic in_span(input logic signed [COORD_W:0] d, input int size);
    return !d[COORD_W] && (int'(d) < size);
  endfunction

endpackage

// File: rtl/sprite_layer_engine_if.sv
// Shadow-register write bus of the sprite layer engine.
// Strobe semantics: every cycle with wr_en high is accepted, there is no
// backpressure; the channel selected by wr_sel takes {wr_x, wr_y, wr_anim, wr_vis}.
`timescale 1ns/1ps
interface sprite_layer_engine_if #(
  parameter int NUM_SPRITES = 4,
  parameter int ANIM_W      = 2
);
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [9:0]        wr_x;
  logic [9:0]        wr_y;
  logic [ANIM_W-1:0] wr_anim;
  logic              wr_vis;

  modport master (output wr_en, wr_sel, wr_x, wr_y, wr_anim, wr_vis);
  modport slave  (input  wr_en, wr_sel, wr_x, wr_y, wr_anim, wr_vis);
endinterface

// File: rtl/sprite_prio_enc.sv
// Lowest-index-wins priority encoder: channel 0 has the highest priority.
`timescale 1ns/1ps
module sprite_prio_enc #(
  parameter int N = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    hits,
  output logic            hit,
  output logic [ID_W-1:0] id
);

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    hit = |hits;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hits[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/sprite_layer_engine.sv
// Per-pixel sprite compositor: double-buffered sprite registers committed on
// the VGA_VS rising edge, three-stage pixel pipeline into a sprite ROM.
// Optional feature macro: SPRITE_COLLISION_EN (per-channel overlap flags).
`timescale 1ns/1ps
module sprite_layer_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int ANIM_W      = 2,
  parameter int COLOR_W     = 4,
  localparam int ID_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int COL_W  = $clog2(SPRITE_W),
  localparam int ROW_W  = $clog2(SPRITE_H),
  localparam int ADDR_W = ID_W + ANIM_W + ROW_W + COL_W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [COLOR_W-1:0]     bg_color,
  sprite_layer_engine_if.slave   wr_bus,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [COLOR_W-1:0]     rom_data,
  output logic [COLOR_W-1:0]     color_index,
  output logic [NUM_SPRITES-1:0] collision
);

  logic vs_meta, vs_sync, vs_prev;
  logic commit;

  sprite_t shadow_q [NUM_SPRITES];
  sprite_t active_q [NUM_SPRITES];

  logic [9:0]         draw_x_s1, draw_y_s1;
  logic [COLOR_W-1:0] bg_s1, bg_s2;
  logic               hit_s2;

  logic signed [10:0]     dx [NUM_SPRITES];
  logic signed [10:0]     dy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hits;
  logic                   win_hit;
  logic [ID_W-1:0]        win_id;

  // Bring VGA_VS into the Clk domain and keep the previous sample for edge detect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= frame_clk;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign commit = vs_sync & ~vs_prev;

  // Shadow bank takes CPU writes; active bank copies the pre-write shadow on commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_bus.wr_en) begin
        shadow_q[wr_bus.wr_sel] <= '{x:    wr_bus.wr_x,
                                     y:    wr_bus.wr_y,
                                     anim: SPRITE_ANIM_W'(wr_bus.wr_anim),
                                     vis:  wr_bus.wr_vis};
      end
    end
  end

  // Stage 1 register: pixel coordinate and its aligned background index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      draw_x_s1 <= '0;
      draw_y_s1 <= '0;
      bg_s1     <= '0;
    end else begin
      draw_x_s1 <= DrawX;
      draw_y_s1 <= DrawY;
      bg_s1     <= bg_color;
    end
  end

  // Per-channel hit test on signed offsets, so partially off-screen sprites clip.
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i]   = coord_diff(draw_x_s1, active_q[i].x);
      dy[i]   = coord_diff(draw_y_s1, active_q[i].y);
      hits[i] = active_q[i].vis && in_span(dx[i], SPRITE_W) && in_span(dy[i], SPRITE_H);
    end
  end

  sprite_prio_enc #(.N(NUM_SPRITES)) u_prio_enc (
    .hits (hits),
    .hit  (win_hit),
    .id   (win_id)
  );

  // Stage 2 register: ROM address of the winning texel (zero when nothing covers the pixel).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_s2   <= 1'b0;
      bg_s2    <= '0;
    end else begin
      rom_addr <= win_hit ? {win_id,
                             ANIM_W'(active_q[win_id].anim),
                             dy[win_id][ROW_W-1:0],
                             dx[win_id][COL_W-1:0]}
                          : '0;
      hit_s2   <= win_hit;
      bg_s2    <= bg_s1;
    end
  end

  // Stage 3 register: winner's texel unless transparent; no fall-through to lower sprites.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      color_index <= '0;
    end else if (!hit_s2 || rom_data == COLOR_W'(TRANSPARENT_IDX)) begin
      color_index <= bg_s2;
    end else begin
      color_index <= rom_data;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] overlap;
  logic [NUM_SPRITES-1:0] coll_acc;

  // A channel overlaps when it hits together with at least one other channel.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      overlap[i] = hits[i] && |(hits & ~(NUM_SPRITES'(1) << i));
    end
  end

  // Sticky per-frame accumulator, published and cleared on commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      coll_acc  <= '0;
      collision <= '0;
    end else if (commit) begin
      collision <= coll_acc;
      coll_acc  <= '0;
    end else begin
      coll_acc  <= coll_acc | overlap;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Self-checking bench for sprite_layer_engine with a scoreboard of expected
// rom_addr / color_index values and a reference model of both sprite banks.
`timescale 1ns/1ps
module tb_sprite_layer_engine;

  localparam int NS     = 4;
  localparam int AW     = 2;
  localparam int CW     = 4;
  localparam int ADDR_W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst;
  logic              frame_clk;
  logic [9:0]        draw_x, draw_y;
  logic [CW-1:0]     bg_color, rom_data, color_index;
  logic [ADDR_W-1:0] rom_addr;
  logic [NS-1:0]     collision;

  sprite_layer_engine_if #(.NUM_SPRITES(NS), .ANIM_W(AW)) wr_bus ();

  sprite_layer_engine #(
    .NUM_SPRITES(NS), .SPRITE_W(16), .SPRITE_H(16), .ANIM_W(AW), .COLOR_W(CW)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .frame_clk   (frame_clk),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .bg_color    (bg_color),
    .wr_bus      (wr_bus),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .color_index (color_index),
    .collision   (collision)
  );

  // External sprite ROM: texel available combinationally for the registered address.
  logic [CW-1:0] rom_mem [1 << ADDR_W];
  assign rom_data = rom_mem[rom_addr];

  // ---------------- reference model ----------------
  int sh_x[NS], sh_y[NS], sh_anim[NS];
  bit sh_vis[NS];
  int act_x[NS], act_y[NS], act_anim[NS];
  bit act_vis[NS];
  logic [NS-1:0] exp_coll_acc;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [CW-1:0]     exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic       drv_valid;
  logic [2:0] vld_sr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_anim[i] = 0; sh_vis[i] = 0;
      act_x[i] = 0; act_y[i] = 0; act_anim[i] = 0; act_vis[i] = 0;
    end
    exp_coll_acc = '0;
  endfunction

  function automatic void model_pixel(input int px, input int py, input logic [CW-1:0] bg,
                                      output logic [ADDR_W-1:0] addr, output logic [CW-1:0] col,
                                      output logic [NS-1:0] hit_v);
    bit found = 0;
    int ox, oy;
    hit_v = '0;
    addr  = '0;
    for (int i = 0; i < NS; i++) begin
      ox = px - act_x[i];
      oy = py - act_y[i];
      if (act_vis[i] && ox >= 0 && ox < 16 && oy >= 0 && oy < 16) begin
        hit_v[i] = 1'b1;
        if (!found) begin
          found = 1;
          addr  = {2'(i), 2'(act_anim[i]), 4'(oy), 4'(ox)};
        end
      end
    end
    col = (!found || rom_mem[addr] == 4'd0) ? bg : rom_mem[addr];
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) vld_sr <= rst ? 3'b000 : {vld_sr[1:0], drv_valid};

  always @(negedge clk) begin
    if (vld_sr[1]) begin
      if (exp_addr_q.size() == 0) check_eq("rom_addr_queue", 32'd0, 32'd1);
      else check_eq("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
    end
    if (vld_sr[2]) begin
      if (exp_q.size() == 0) check_eq("color_queue", 32'd0, 32'd1);
      else check_eq("color_index", 32'(color_index), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_pix(input int px, input int py, input logic [CW-1:0] bg);
    logic [ADDR_W-1:0] a;
    logic [CW-1:0]     c;
    logic [NS-1:0]     h;
    draw_x    = 10'(px);
    draw_y    = 10'(py);
    bg_color  = bg;
    drv_valid = 1'b1;
    model_pixel(px, py, bg, a, c, h);
    exp_addr_q.push_back(a);
    exp_q.push_back(c);
    if ($countones(h) >= 2) exp_coll_acc |= h;
    tick();
  endtask

  // Park the pixel far from every sprite and let the pipeline drain.
  task automatic park();
    draw_x    = 10'd1023;
    draw_y    = 10'd1023;
    bg_color  = '0;
    drv_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic write_ch(input int ch, input int x, input int y, input int anim, input bit vis);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_sel  = 2'(ch);
    wr_bus.wr_x    = 10'(x);
    wr_bus.wr_y    = 10'(y);
    wr_bus.wr_anim = 2'(anim);
    wr_bus.wr_vis  = vis;
    tick();
    wr_bus.wr_en = 1'b0;
    sh_x[ch] = x; sh_y[ch] = y; sh_anim[ch] = anim; sh_vis[ch] = vis;
  endtask

  // VS pulse; optionally writes in the commit cycle (third Clk after the rising edge).
  task automatic vs_commit(input bit do_wr, input int ch, input int x, input int y,
                           input int anim, input bit vis);
    logic [NS-1:0] exp_coll;
    frame_clk = 1'b1;
    tick();
    tick();
    if (do_wr) begin
      wr_bus.wr_en   = 1'b1;
      wr_bus.wr_sel  = 2'(ch);
      wr_bus.wr_x    = 10'(x);
      wr_bus.wr_y    = 10'(y);
      wr_bus.wr_anim = 2'(anim);
      wr_bus.wr_vis  = vis;
    end
    tick();
    wr_bus.wr_en = 1'b0;
    for (int i = 0; i < NS; i++) begin
      act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_anim[i] = sh_anim[i]; act_vis[i] = sh_vis[i];
    end
    if (do_wr) begin
      sh_x[ch] = x; sh_y[ch] = y; sh_anim[ch] = anim; sh_vis[ch] = vis;
    end
`ifdef SPRITE_COLLISION_EN
    exp_coll = exp_coll_acc;
`else
    exp_coll = '0;
`endif
    exp_coll_acc = '0;
    check_eq("collision", 32'(collision), 32'(exp_coll));
    frame_clk = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; frame_clk = 1'b0; drv_valid = 1'b0;
    draw_x = 10'd1023; draw_y = 10'd1023; bg_color = '0;
    wr_bus.wr_en = 1'b0; wr_bus.wr_sel = '0; wr_bus.wr_x = '0; wr_bus.wr_y = '0;
    wr_bus.wr_anim = '0; wr_bus.wr_vis = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[12'h100] = 4'd7;   // ch0, anim 1, row 0, col 0
    rom_mem[12'h135] = 4'd0;   // ch0, anim 1, row 3, col 5: transparent
    rom_mem[12'hA35] = 4'd9;   // ch2, anim 2, row 3, col 5
    model_clear();

    // Reset state
    repeat (3) tick();
    check_eq("reset_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("reset_color", 32'(color_index), 32'd0);
    check_eq("reset_collision", 32'(collision), 32'd0);
    rst = 1'b0;
    tick();

    // Background only
    repeat (3) drive_pix(100, 100, 4'd5);
    park();

    // Shadow write without commit stays invisible; after VS it shows
    write_ch(0, 100, 100, 1, 1'b1);
    repeat (2) drive_pix(100, 100, 4'd3);
    park();
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    drive_pix(100, 100, 4'd3);
    drive_pix(101, 100, 4'd2);
    drive_pix(115, 115, 4'd1);
    drive_pix(116, 100, 4'd6);
    drive_pix(99, 100, 4'd4);
    drive_pix(100, 116, 4'd8);
    park();

    // Transparent winner texel hides the lower-priority sprite
    write_ch(2, 100, 100, 2, 1'b1);
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    drive_pix(105, 103, 4'd6);
    drive_pix(105, 103, 4'd6);
    drive_pix(100, 100, 4'd2);
    drive_pix(110, 108, 4'd1);
    park();

    // Right/bottom edge clipping, no wrap to DrawX 0
    write_ch(0, 0, 0, 0, 1'b0);
    write_ch(2, 0, 0, 0, 1'b0);
    write_ch(1, 632, 470, 3, 1'b1);
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    for (int x = 628; x < 640; x++) drive_pix(x, 470, 4'(x));
    for (int x = 0; x < 4; x++) drive_pix(x, 470, 4'd11);
    drive_pix(639, 479, 4'd12);
    drive_pix(631, 479, 4'd13);
    drive_pix(635, 469, 4'd14);
    park();

    // Write in the commit cycle lands one frame later
    vs_commit(1, 3, 200, 200, 0, 1'b1);
    repeat (2) drive_pix(205, 205, 4'd8);
    park();
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    repeat (2) drive_pix(205, 205, 4'd8);
    park();

    // Overlap of ch0 and ch3, then a frame without overlap
    write_ch(0, 210, 210, 2, 1'b1);
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    drive_pix(212, 212, 4'd4);
    drive_pix(215, 215, 4'd4);
    drive_pix(200, 200, 4'd4);
    park();
    vs_commit(0, 0, 0, 0, 0, 1'b0);
    vs_commit(0, 0, 0, 0, 0, 1'b0);

    // Random pixels around the active sprites
    for (int n = 0; n < 120; n++) begin
      if (n % 3 == 0) drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 4'($urandom_range(0, 15)));
      else if (n % 3 == 1) drive_pix($urandom_range(195, 230), $urandom_range(195, 230), 4'($urandom_range(0, 15)));
      else drive_pix($urandom_range(620, 639), $urandom_range(460, 479), 4'($urandom_range(0, 15)));
    end
    park();
    vs_commit(0, 0, 0, 0, 0, 1'b0);

    // Reset with sprites active: outputs clear, banks clear, background only
    rst = 1'b1;
    tick();
    check_eq("midreset_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("midreset_color", 32'(color_index), 32'd0);
    check_eq("midreset_collision", 32'(collision), 32'd0);
    rst = 1'b0;
    model_clear();
    drive_pix(212, 212, 4'd10);
    drive_pix(205, 205, 4'd11);
    drive_pix(635, 475, 4'd12);
    park();

    if (exp_q.size() != 0 || exp_addr_q.size() != 0)
      check_eq("scoreboard_drained", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sprite_layer_engine.md
# sprite_layer_engine

Parametrised per-pixel sprite compositor that replaces the single-sprite pac_controller/draw_control pairing. It holds position, animation frame and enable state for NUM_SPRITES sprites (Pacman plus ghosts) in double-buffered registers, and commits them at each vertical-sync rising edge. For every DrawX/DrawY it selects the highest-priority covering sprite, fetches its texel from the external sprite ROM and emits a 4-bit colour index for color_mapper. It sits between VGA_controller/frameRAM and color_mapper.

## Interface
- NUM_SPRITES, 4: sprite channels; channel 0 has the highest priority.
- SPRITE_W, 16: sprite width in pixels, power of two.
- SPRITE_H, 16: sprite height in pixels, power of two.
- ANIM_W, 2: animation-frame index width.
- COLOR_W, 4: colour index width.
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  reset, synchronous, active-high.
- frame_clk  in  1  VGA_VS; asynchronous to Clk.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- bg_color  in  COLOR_W  background index from frameRAM, aligned with DrawX/DrawY.
- wr_en  in  1  shadow-register write strobe.
- wr_sel  in  $clog2(NUM_SPRITES)  target channel.
- wr_x, wr_y  in  10 each  sprite top-left coordinate.
- wr_anim  in  ANIM_W  animation frame.
- wr_vis  in  1  sprite visible.
- rom_addr  out  $clog2(NUM_SPRITES)+ANIM_W+$clog2(SPRITE_H)+$clog2(SPRITE_W)  sprite ROM address; field order {id, anim, row, col}.
- rom_data  in  COLOR_W  ROM texel; valid 1 cycle after rom_addr.
- color_index  out  COLOR_W  composited colour.
- collision  out  NUM_SPRITES  per-channel overlap flags for the previous frame (when SPRITE_COLLISION_EN is defined).

## Operation
- frame_clk passes through a 2-flop synchroniser. A rising edge on the synchronised signal is the commit pulse.
- Shadow bank: when wr_en is high, the channel selected by wr_sel latches {wr_x, wr_y, wr_anim, wr_vis}.
- Active bank: on the commit pulse, all channels copy the shadow bank. The copy uses the shadow contents from before that cycle's write, so a write in the commit cycle takes effect at the next commit.
- Hit test, per channel: vis && DrawX−x ∈ [0, SPRITE_W) && DrawY−y ∈ [0, SPRITE_H).
  - Subtraction is 11-bit signed, so there is no wrap-around.
  - Sprites partially off-screen clip correctly.
  - x = 1023 never matches DrawX 0..639.
- Priority: the lowest-index hit wins. Its offsets (col, row) form rom_addr.
- Compose: if there was no hit, or rom_data == 0 (transparent), color_index = delayed bg_color. Otherwise color_index = rom_data.
- Lower-priority sprites are never shown beneath a transparent texel of the winner.
- Reset clears both banks (vis = 0) and the synchroniser. Outputs reset to rom_addr = 0, color_index = 0, collision = 0.
- Reset mid-frame takes effect on the next cycle. The pipeline shows background data within 3 cycles.

## Timing
- Stage 1: register DrawX/DrawY/bg_color, evaluate hits and the priority encoder.
- Stage 2: register rom_addr, the hit flag and bg_color.
- Stage 3: rom_data arrives and color_index is registered.
- Latency from DrawX/DrawY/bg_color to color_index is 3 Clk cycles. The caller aligns bg_color to the same cycle as DrawX.
- Commit happens 3 Clk cycles after the VGA_VS rising edge (2 synchroniser cycles + 1 edge detect).
- Throughput: one pixel per Clk. Repeated coordinates at 50 MHz (VGA_CLK = 25 MHz) are legal and idempotent.

## Configuration
- SPRITE_COLLISION_EN defined:
  - During a frame, a sticky accumulator sets bit i whenever channel i hits on a pixel where at least one other channel also hits.
  - At commit, collision ← accumulator and the accumulator clears.
- SPRITE_COLLISION_EN undefined: the accumulator logic is absent and collision is tied to 0.

## Structure
- sprite_pkg holds:
  - the sprite_t struct {x, y, anim, vis};
  - the TRANSPARENT_IDX = 0 constant;
  - the SCREEN_W = 640 and SCREEN_H = 480 constants.
- One sub-module, sprite_prio_enc: a combinational lowest-index priority encoder returning {hit, id}.

## Test plan
- Reset, then no writes, DrawX=100, DrawY=100, bg_color=5 → color_index=5 after 3 cycles; rom_addr=0.
- Write ch0 at x=100, y=100, vis=1, anim=1 with no commit → color_index stays bg. After the VS pulse → rom_addr={0,1,0,0} for (100,100) and color_index=rom_data=7 three cycles after DrawX.
- Ch0 and ch2 both cover (105,103), with ch0's texel transparent (0) and ch2's texel = 9 → color_index = bg_color (ch0 wins). rom_addr = {0, anim, 3, 5}.
- Ch1 at x=632, y=470 → hits at DrawX 632..639 only; DrawX=0 never hits (no wrap).
- wr_en in the same cycle as the commit pulse → the old values remain active for that frame; the new values are active after the following VS.
- With SPRITE_COLLISION_EN: ch0 overlaps ch3 for one frame → after the next commit collision=4'b1001; the frame after with no overlap → 4'b0000.
